// File: rtl/count_sequencer_if.sv
// Host/counter-facing signal bundle for count_sequencer.
// Protocol: start is taken only while busy is low; done pulses once per completed sequence, pass is valid from the cycle after done.
interface count_sequencer_if #(
  parameter int LEN_W = 5,
  parameter int CNT_W = 4
);
  logic             start;
  logic [LEN_W-1:0] run_len;
  logic             pause;
  logic             abort;
  logic [CNT_W-1:0] count_in;
  logic             cnt_reset;
  logic             cnt_enable;
  logic             busy;
  logic             done;
  logic             pass;

  modport master (
    output start, run_len, pause, abort, count_in,
    input  cnt_reset, cnt_enable, busy, done, pass
  );

  modport slave (
    input  start, run_len, pause, abort, count_in,
    output cnt_reset, cnt_enable, busy, done, pass
  );
endinterface

// File: rtl/count_sequencer.sv
// Clears the downstream counter, enables it for a programmed number of cycles,
// then checks the read-back value against the expected modulo-2^CNT_W count.
module count_sequencer #(
  parameter int CLR_CYCLES = 2,
  parameter int LEN_W      = 5,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  count_sequencer_if.slave      bus,
  output logic [1:0]            state_dbg
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] run_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic             pass_q;

  logic             cnt_reset_c;
  logic             cnt_enable_c;
  logic             done_c;
  logic             clr_last;
  logic             run_last;

  assign clr_last = (clr_cnt == CLR_W'(CLR_CYCLES - 1));
  assign run_last = (run_cnt == (len_q - LEN_W'(1)));

  always_comb begin
    state_nxt    = state;
    cnt_reset_c  = 1'b0;
    cnt_enable_c = 1'b0;
    done_c       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_reset_c = 1'b1;
        if (bus.abort)     state_nxt = IDLE;
        else if (clr_last) state_nxt = (len_q != '0) ? RUN : CHECK;
      end
      RUN: begin
        // pause and abort gate the enable in the same cycle they are seen
        cnt_enable_c = ~bus.pause & ~bus.abort;
        if (bus.abort)                     state_nxt = IDLE;
        else if (cnt_enable_c && run_last) state_nxt = CHECK;
      end
      CHECK: begin
        done_c    = ~bus.abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      len_q   <= '0;
      run_cnt <= '0;
      clr_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            len_q   <= bus.run_len;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + CLR_W'(1);
          run_cnt <= '0;
        end
        RUN: begin
          if (cnt_enable_c) run_cnt <= run_cnt + LEN_W'(1);
        end
        CHECK: begin
          // expected count is len_q truncated to the counter width
          if (!bus.abort) pass_q <= (bus.count_in == len_q[CNT_W-1:0]);
        end
        default: ;
      endcase
    end
  end

  assign bus.cnt_reset  = cnt_reset_c;
  assign bus.cnt_enable = cnt_enable_c;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_c;
  assign bus.pass       = pass_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: a behavioural 4-bit counter closes the loop,
// a scoreboard queue holds the expected result of each completed sequence.
module tb_count_sequencer;

  localparam int CLR = 2;
  localparam int LW  = 5;
  localparam int CW  = 4;
  localparam int EW  = 1 + CW + 8 + 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  count_sequencer_if #(.LEN_W(LW), .CNT_W(CW)) bus ();

  count_sequencer #(.CLR_CYCLES(CLR), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Counter model, with an optional skipped increment at enable index skip_at
  logic [CW-1:0] ctr = '0;
  int            en_idx = 0;
  int            skip_at = -1;

  always @(posedge clk) begin
    if (bus.cnt_reset) begin
      ctr    <= '0;
      en_idx <= 0;
    end else if (bus.cnt_enable) begin
      en_idx <= en_idx + 1;
      if (en_idx != skip_at) ctr <= ctr + CW'(1);
    end
  end

  assign bus.count_in = ctr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard: {pass, count, latency, enable cycles}
  logic [EW-1:0] exp_q[$];
  int            start_cyc = 0;

  task automatic expect_seq(input int cnt, input int pas, input int lat, input int en);
    exp_q.push_back({1'(pas), CW'(cnt), 8'(lat), 6'(en)});
  endtask

  // Monitor: counts clear/enable cycles, checks every done pulse
  initial begin
    int            en_seen;
    int            clr_seen;
    logic          prev_rst;
    logic [EW-1:0] e;
    en_seen  = 0;
    clr_seen = 0;
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_rst = 1'b0;
      end else begin
        if (bus.cnt_reset) begin
          if (!prev_rst) begin
            clr_seen = 0;
            en_seen  = 0;
          end
          clr_seen++;
        end
        prev_rst = bus.cnt_reset;
        if (bus.cnt_enable) en_seen++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("count_in", int'(bus.count_in), int'(e[17:14]));
            check("latency", cyc - start_cyc, int'(e[13:6]));
            check("enable_cycles", en_seen, int'(e[5:0]));
            check("clear_cycles", clr_seen, CLR);
            @(posedge clk);
            #1;
            check("pass", int'(bus.pass), int'(e[18]));
          end
        end
      end
    end
  end

  task automatic start_seq(input int len);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.run_len = LW'(len);
    start_cyc   = cyc;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.run_len = LW'($urandom_range(0, 31));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, int'(bus.busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.run_len = '0;
    bus.pause   = 1'b0;
    bus.abort   = 1'b0;

    #2;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_cnt_reset", int'(bus.cnt_reset), 0);
    check("rst_cnt_enable", int'(bus.cnt_enable), 0);
    check("rst_pass", int'(bus.pass), 0);
    check("rst_state", int'(state_dbg), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(bus.busy), 0);

    // Basic, wrap, zero length
    expect_seq(5, 1, 8, 5);   start_seq(5);  wait_idle("basic");
    expect_seq(0, 1, 19, 16); start_seq(16); wait_idle("wrap16");
    expect_seq(5, 1, 24, 21); start_seq(21); wait_idle("wrap21");
    expect_seq(0, 1, 3, 0);   start_seq(0);  wait_idle("zero");

    // Pause for 3 cycles after the 2nd enable
    expect_seq(4, 1, 10, 4);
    start_seq(4);
    repeat (4) @(negedge clk);
    bus.pause = 1'b1;
    #1;
    check("pause_gate", int'(bus.cnt_enable), 0);
    repeat (3) @(negedge clk);
    bus.pause = 1'b0;
    wait_idle("pause");

    // Abort on the 3rd RUN cycle
    start_seq(10);
    repeat (4) @(negedge clk);
    check("pre_abort_enable", int'(bus.cnt_enable), 1);
    bus.abort = 1'b1;
    #1;
    check("abort_gate", int'(bus.cnt_enable), 0);
    check("abort_no_done", int'(bus.done), 0);
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_idle", int'(bus.busy), 0);
    check("abort_pass_hold", int'(bus.pass), 1);

    // start and abort together in IDLE
    @(negedge clk);
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.run_len = LW'(7);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort_busy", int'(bus.busy), 0);
    check("start_abort_state", int'(state_dbg), 0);

    // Counter skips one increment
    skip_at = 2;
    expect_seq(5, 0, 9, 6);
    start_seq(6);
    wait_idle("mismatch");
    skip_at = -1;

    // start during RUN is dropped
    expect_seq(8, 1, 11, 8);
    start_seq(8);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("start_in_run");
    repeat (2) @(negedge clk);
    check("start_not_queued", int'(bus.busy), 0);

    // Asynchronous reset mid-RUN
    start_seq(10);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_cnt_enable", int'(bus.cnt_enable), 0);
    check("async_busy", int'(bus.busy), 0);
    check("async_pass", int'(bus.pass), 0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_seq(3, 1, 6, 3);
    start_seq(3);
    wait_idle("after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Control stage directly upstream of the 4-bit enable/reset counter. On a start request it issues a clear burst on the counter's synchronous reset, then holds the counter's enable for exactly a programmed number of cycles, honouring pause and abort. It then reads back the counter value, checks it against the expected modulo-16 count, and reports done/pass to the testbench or host sequencer.

Parameters:
CLR_CYCLES, 2, number of cycles cnt_reset is held high in CLEAR (minimum 1)
LEN_W, 5, width of run_len; allows 0..31 enable cycles
CNT_W, 4, width of the counter value read back on count_in

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a sequence; sampled only in IDLE
run_len  input  LEN_W  number of enable cycles; latched on accepted start
pause  input  1  while high in RUN, cnt_enable is low and the run count holds
abort  input  1  synchronous cancel of any active sequence
count_in  input  CNT_W  counter output (data) fed back from the counter
cnt_reset  output  1  drives the counter's synchronous active-high reset
cnt_enable  output  1  drives the counter's enable
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on sequence completion (not on abort)
pass  output  1  result of the last completed check; holds until the next done

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, len_q=0, run_cnt=0, clr_cnt=0, pass=0. Outputs cnt_reset, cnt_enable, busy and done go low immediately and stay low while reset_n is low.
- FSM states: IDLE, CLEAR, RUN, CHECK. State is registered. Outputs are Moore decodes, except that abort and pause gate cnt_enable combinationally.
- IDLE: all control outputs low. If start=1 and abort=0: latch len_q<=run_len, clr_cnt<=0, go to CLEAR. If start and abort are high in the same cycle, abort wins and the block stays in IDLE.
- CLEAR: cnt_reset=1 for exactly CLR_CYCLES consecutive cycles. After the last one, go to RUN if len_q!=0, else go to CHECK. run_cnt is cleared on entry.
- RUN: cnt_enable = ~pause & ~abort. run_cnt increments on each edge where cnt_enable=1. On the edge where cnt_enable=1 and run_cnt==len_q-1, go to CHECK. cnt_enable is therefore high for exactly len_q cycles, which need not be contiguous.
- CHECK: lasts one cycle. The counter has registered its final increment, so count_in is valid. Register pass <= (count_in == len_q[CNT_W-1:0]), pulse done=1 for this cycle, then return to IDLE.
- Width rule: the expected value is len_q modulo 2^CNT_W. run_len=16 therefore expects 0, and run_len=21 expects 5.
- Latency with no pause: start accepted at cycle 0, then CLEAR for cycles 1..CLR_CYCLES, RUN for len_q cycles, then CHECK with done high. Total from accepted start to done is CLR_CYCLES+len_q+1 cycles.
- abort in CLEAR, RUN or CHECK: cnt_enable forced low in the same cycle. Next state is IDLE, done is not pulsed, and pass keeps its previous value. An abort in IDLE has no effect.
- start while busy is ignored, and is not queued.
- run_len changing after acceptance has no effect, because len_q is held.
- pause in CLEAR or CHECK has no effect.

Test Plan:
- Basic run: run_len=5, CLR_CYCLES=2, model counter attached -> cnt_reset high 2 cycles, cnt_enable high 5 cycles, done pulses at cycle 8 after start, count_in=5, pass=1.
- Wrap: run_len=16 -> 16 enable cycles, counter wraps to 0, expected 0, pass=1. Repeat with run_len=21 -> count_in=5, pass=1.
- Zero length and pause: run_len=0 -> no cnt_enable, done at cycle 3 after start, pass=1 with count_in=0. run_len=4 with pause high for 3 cycles after the 2nd enable -> cnt_enable high 4 cycles over a 7-cycle RUN, pass=1.
- Abort and start rules: abort asserted on the 3rd RUN cycle with run_len=10 -> cnt_enable low that cycle, IDLE next, no done, pass unchanged. start and abort together in IDLE -> stays IDLE. start during RUN -> ignored.
- Mismatch: counter model forced to skip one increment, run_len=6 -> count_in=5 at CHECK, done=1, pass=0.
- Async reset: reset_n driven low mid-RUN between clock edges -> cnt_enable and busy low immediately, pass=0. After release, a fresh run_len=3 sequence completes with pass=1.
